// File: rtl/coralnpu_cosim_retire_collector.sv
// Retirement collector for the MPACT cosim checker: compacts up to NRET in-order retire lanes
// per cycle into a FIFO and streams them one at a time with sequence numbers and drop tracking.
module coralnpu_cosim_retire_collector #(
  parameter int unsigned NRET   = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned SEQ_W  = 32,
  parameter int unsigned DROP_W = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NRET-1:0]            retire_valid,
  input  logic [NRET*32-1:0]         retire_pc,
  input  logic [NRET*32-1:0]         retire_insn,
  input  logic [NRET*5-1:0]          retire_rd_addr,
  input  logic [NRET-1:0]            retire_rd_wen,
  input  logic [NRET*32-1:0]         retire_rd_data,
  input  logic                       halt,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [31:0]                trace_pc,
  output logic [31:0]                trace_insn,
  output logic [4:0]                 trace_rd_addr,
  output logic                       trace_rd_wen,
  output logic [31:0]                trace_rd_data,
  output logic [SEQ_W-1:0]           trace_seq,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count,
  output logic                       drained
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = DROP_W + 1;

  logic [31:0]      pc_mem      [DEPTH];
  logic [31:0]      insn_mem    [DEPTH];
  logic [4:0]       rd_addr_mem [DEPTH];
  logic             rd_wen_mem  [DEPTH];
  logic [31:0]      rd_data_mem [DEPTH];
  logic [SEQ_W-1:0] seq_mem     [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [DROP_W-1:0] drop_count_q, drop_count_d;
  logic              overflow_q, overflow_d;
  logic              halt_seen_q, halt_seen_d;
  logic              drained_q, drained_d;

  logic [CNT_W-1:0]  free, accepted, dropped;
  logic [SUM_W-1:0]  drop_sum;
  logic              pop;
  logic [NRET-1:0]   lane_acc;
  logic [PTR_W-1:0]  lane_slot [NRET];
  logic [SEQ_W-1:0]  lane_seq  [NRET];

  // Compaction: accepted lanes take consecutive slots in ascending lane order. Space comes
  // only from the registered count, so a same-cycle pop never frees room for this push.
  always_comb begin
    free     = CNT_W'(DEPTH) - count_q;
    accepted = '0;
    dropped  = '0;
    for (int i = 0; i < NRET; i++) begin
      lane_acc[i]  = 1'b0;
      lane_slot[i] = wr_ptr_q + PTR_W'(accepted);
      lane_seq[i]  = seq_q + SEQ_W'(accepted);
      if (retire_valid[i] && !halt_seen_q) begin
        if (accepted < free) begin
          lane_acc[i] = 1'b1;
          accepted    = accepted + CNT_W'(1);
        end else begin
          dropped = dropped + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    pop         = (count_q != '0) && trace_ready;
    count_d     = count_q + accepted - CNT_W'(pop);
    wr_ptr_d    = wr_ptr_q + PTR_W'(accepted);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    seq_d       = seq_q + SEQ_W'(accepted);
    drop_sum    = {1'b0, drop_count_q} + SUM_W'(dropped);
    drop_count_d = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    overflow_d  = overflow_q | (dropped != '0);
    halt_seen_d = halt_seen_q | halt;
    // Built from next-state so drained rises together with count reaching zero.
    drained_d   = halt_seen_d && (count_d == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      seq_q        <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
      halt_seen_q  <= 1'b0;
      drained_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      seq_q        <= seq_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
      halt_seen_q  <= halt_seen_d;
      drained_q    <= drained_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NRET; i++) begin
      if (!reset && lane_acc[i]) begin
        pc_mem[lane_slot[i]]      <= retire_pc[32*i +: 32];
        insn_mem[lane_slot[i]]    <= retire_insn[32*i +: 32];
        rd_addr_mem[lane_slot[i]] <= retire_rd_addr[5*i +: 5];
        rd_wen_mem[lane_slot[i]]  <= retire_rd_wen[i];
        rd_data_mem[lane_slot[i]] <= retire_rd_data[32*i +: 32];
        seq_mem[lane_slot[i]]     <= lane_seq[i];
      end
    end
  end

  always_comb begin
    trace_valid   = (count_q != '0);
    trace_pc      = pc_mem[rd_ptr_q];
    trace_insn    = insn_mem[rd_ptr_q];
    trace_rd_addr = rd_addr_mem[rd_ptr_q];
    trace_rd_wen  = rd_wen_mem[rd_ptr_q];
    trace_rd_data = rd_data_mem[rd_ptr_q];
    trace_seq     = seq_mem[rd_ptr_q];
    count         = count_q;
    overflow      = overflow_q;
    drop_count    = drop_count_q;
    drained       = drained_q;
  end

endmodule

// File: tb/tb_coralnpu_cosim_retire_collector.sv
// Directed bench for the retire collector: compaction, space rule, drops, halt/drain and reset.
module tb_coralnpu_cosim_retire_collector;

  localparam int unsigned NRET = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [NRET-1:0]   retire_valid;
  logic [NRET*32-1:0] retire_pc, retire_insn, retire_rd_data;
  logic [NRET*5-1:0] retire_rd_addr;
  logic [NRET-1:0]   retire_rd_wen;
  logic              halt;
  logic              trace_valid, trace_ready;
  logic [31:0]       trace_pc, trace_insn, trace_rd_data;
  logic [4:0]        trace_rd_addr;
  logic              trace_rd_wen;
  logic [31:0]       trace_seq;
  logic [4:0]        count;
  logic              overflow;
  logic [15:0]       drop_count;
  logic              drained;

  int checks = 0;
  int errors = 0;

  coralnpu_cosim_retire_collector dut (
    .clock(clock), .reset(reset),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_insn(retire_insn),
    .retire_rd_addr(retire_rd_addr), .retire_rd_wen(retire_rd_wen),
    .retire_rd_data(retire_rd_data), .halt(halt),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
    .trace_insn(trace_insn), .trace_rd_addr(trace_rd_addr), .trace_rd_wen(trace_rd_wen),
    .trace_rd_data(trace_rd_data), .trace_seq(trace_seq), .count(count),
    .overflow(overflow), .drop_count(drop_count), .drained(drained)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Lane payload is derived from pc so checks need only the pc.
  task automatic set_lane(input int lane, input logic [31:0] pc);
    retire_valid[lane]            = 1'b1;
    retire_pc[32*lane +: 32]      = pc;
    retire_insn[32*lane +: 32]    = pc ^ 32'h0000_0013;
    retire_rd_addr[5*lane +: 5]   = pc[6:2];
    retire_rd_wen[lane]           = pc[2];
    retire_rd_data[32*lane +: 32] = ~pc;
  endtask

  task automatic clear_lanes();
    retire_valid = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_lanes();
    halt = 1'b0;
    trace_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_head(input string name, input logic [31:0] pc, input logic [31:0] seq);
    checks++;
    if (trace_valid !== 1'b1 || trace_pc !== pc || trace_seq !== seq ||
        trace_insn !== (pc ^ 32'h13) || trace_rd_data !== ~pc ||
        trace_rd_addr !== pc[6:2] || trace_rd_wen !== pc[2]) begin
      errors++;
      $display("FAIL %s: got valid=%0b pc=%h seq=%0d insn=%h rd=%0d wen=%0b data=%h exp pc=%h seq=%0d",
               name, trace_valid, trace_pc, trace_seq, trace_insn, trace_rd_addr,
               trace_rd_wen, trace_rd_data, pc, seq);
    end
  endtask

  task automatic chk_state(input string name, input logic [4:0] cnt, input logic ovf,
                           input logic [15:0] drops, input logic drn);
    checks++;
    if (count !== cnt || trace_valid !== (cnt != 0) || overflow !== ovf ||
        drop_count !== drops || drained !== drn) begin
      errors++;
      $display("FAIL %s: got count=%0d valid=%0b ovf=%0b drops=%0d drained=%0b exp %0d %0b %0b %0d %0b",
               name, count, trace_valid, overflow, drop_count, drained,
               cnt, cnt != 0, ovf, drops, drn);
    end
  endtask

  task automatic test_reset();
    do_reset();
    chk_state("reset_state", 5'd0, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic test_single();
    do_reset();
    set_lane(0, 32'h8000_0000);
    tick();
    clear_lanes();
    chk_state("single_count", 5'd1, 1'b0, 16'd0, 1'b0);
    chk_head("single_head", 32'h8000_0000, 0);
    // Head must hold while not accepted.
    tick();
    chk_head("single_hold", 32'h8000_0000, 0);
    trace_ready = 1'b1;
    tick();
    chk_state("single_pop", 5'd0, 1'b0, 16'd0, 1'b0);
    // Ready while empty is harmless.
    tick();
    chk_state("single_ready_empty", 5'd0, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic test_sparse();
    do_reset();
    set_lane(1, 32'h0000_0104);
    set_lane(3, 32'h0000_010C);
    tick();
    clear_lanes();
    chk_state("sparse_count", 5'd2, 1'b0, 16'd0, 1'b0);
    chk_head("sparse_head0", 32'h104, 0);
    trace_ready = 1'b1;
    tick();
    chk_head("sparse_head1", 32'h10C, 1);
    tick();
    chk_state("sparse_empty", 5'd0, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) set_lane(i, 32'h1000 + 32'(4 * (4 * c + i)));
      tick();
    end
    chk_state("fill_full", 5'd16, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 4; i++) set_lane(i, 32'hBAD0);
    tick();
    clear_lanes();
    chk_state("fill_overflow", 5'd16, 1'b1, 16'd4, 1'b0);
    trace_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk_head($sformatf("fill_pop%0d", k), 32'h1000 + 32'(4 * k), 32'(k));
      tick();
    end
    chk_state("fill_drained", 5'd0, 1'b1, 16'd4, 1'b0);
  endtask

  task automatic test_partial();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) if (c < 3 || i < 2) set_lane(i, 32'h2000 + 32'(4 * (4 * c + i)));
      tick();
      clear_lanes();
    end
    chk_state("partial_14", 5'd14, 1'b0, 16'd0, 1'b0);
    set_lane(0, 32'h2000 + 32'(4 * 14));
    set_lane(1, 32'h2000 + 32'(4 * 15));
    set_lane(2, 32'hBAD0);
    set_lane(3, 32'hBAD0);
    tick();
    clear_lanes();
    chk_state("partial_fit", 5'd16, 1'b1, 16'd2, 1'b0);
    // Full with a pop in the same cycle: the push still has no room.
    set_lane(0, 32'hBAD4);
    trace_ready = 1'b1;
    tick();
    clear_lanes();
    chk_state("partial_pop_nospace", 5'd15, 1'b1, 16'd3, 1'b0);
    for (int k = 1; k < 16; k++) begin
      chk_head($sformatf("partial_pop%0d", k), 32'h2000 + 32'(4 * k), 32'(k));
      tick();
    end
    chk_state("partial_empty", 5'd0, 1'b1, 16'd3, 1'b0);
  endtask

  task automatic test_halt();
    do_reset();
    set_lane(0, 32'h3000);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    for (int i = 0; i < 4; i++) set_lane(i, 32'hBAD0);
    chk_state("halt_accept", 5'd1, 1'b0, 16'd0, 1'b0);
    chk_head("halt_head", 32'h3000, 0);
    tick();
    chk_state("halt_ignore", 5'd1, 1'b0, 16'd0, 1'b0);
    trace_ready = 1'b1;
    tick();
    chk_state("halt_drained", 5'd0, 1'b0, 16'd0, 1'b1);
    tick();
    clear_lanes();
    chk_state("halt_sticky", 5'd0, 1'b0, 16'd0, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) set_lane(i, 32'h4000 + 32'(4 * (4 * c + i)));
      tick();
    end
    clear_lanes();
    set_lane(0, 32'hBAD0);
    tick();
    clear_lanes();
    trace_ready = 1'b1;
    repeat (9) tick();
    trace_ready = 1'b0;
    chk_state("mid_before", 5'd7, 1'b1, 16'd1, 1'b0);
    chk_head("mid_head", 32'h4000 + 32'(4 * 9), 9);
    do_reset();
    chk_state("mid_after_reset", 5'd0, 1'b0, 16'd0, 1'b0);
    set_lane(0, 32'h5000);
    tick();
    clear_lanes();
    chk_head("mid_seq0", 32'h5000, 0);
  endtask

  initial begin
    reset = 1'b1;
    retire_valid = '0;
    retire_pc = '0;
    retire_insn = '0;
    retire_rd_addr = '0;
    retire_rd_wen = '0;
    retire_rd_data = '0;
    halt = 1'b0;
    trace_ready = 1'b0;
    tick();
    test_reset();
    test_single();
    test_sparse();
    test_fill_overflow();
    test_partial();
    test_halt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
